elbeth_mem_arbiter: RTL

- Shares one single-port memory bus between the IF-stage instruction fetch port and the EX/MEM-stage data port of the ELBETH pipeline.
- Sequences each access as a registered request/ready handshake toward the memory.
- Returns the `*_ready` pulses that drive the control unit's `if_stall`/`id_stall` logic.
- Includes round-robin arbitration and a per-access timeout that reports a bus error instead of deadlocking the pipeline.

---
 rtl/elbeth_mem_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/elbeth_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory bus between the ELBETH
// instruction-fetch port and the data port, with a per-access bus timeout.
module elbeth_mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_en,
    input  logic [ADDR_W-1:0] imem_addr,
    output logic              imem_ready,
    output logic [DATA_W-1:0] imem_rdata,
    output logic              imem_error,
    input  logic              dmem_en,
    input  logic              dmem_rw,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_wdata,
    input  logic [3:0]        dmem_byte_en,
    output logic              dmem_ready,
    output logic [DATA_W-1:0] dmem_rdata,
    output logic              dmem_error,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_byte_en,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, IMEM_ACC, DMEM_ACC} state_e;

    // Abort fires in the last allowed cycle, so mem_en stays high TIMEOUT_CYCLES cycles.
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);

    state_e              state_q, state_d;
    logic                last_dmem_q, last_dmem_d;
    logic [9:0]          cnt_q, cnt_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]          mem_be_q, mem_be_d;
    logic                imem_ready_q, imem_ready_d;
    logic [DATA_W-1:0]   imem_rdata_q, imem_rdata_d;
    logic                imem_error_q, imem_error_d;
    logic                dmem_ready_q, dmem_ready_d;
    logic [DATA_W-1:0]   dmem_rdata_q, dmem_rdata_d;
    logic                dmem_error_q, dmem_error_d;
    logic                i_elig, d_elig;

    // The ready mask hides the one-cycle tail of en after a completion.
    assign i_elig = imem_en & ~imem_ready_q;
    assign d_elig = dmem_en & ~dmem_ready_q;

    always_comb begin
        state_d      = state_q;
        last_dmem_d  = last_dmem_q;
        cnt_d        = cnt_q;
        mem_en_d     = mem_en_q;
        mem_rw_d     = mem_rw_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        imem_ready_d = 1'b0;
        imem_rdata_d = imem_rdata_q;
        imem_error_d = imem_error_q;
        dmem_ready_d = 1'b0;
        dmem_rdata_d = dmem_rdata_q;
        dmem_error_d = dmem_error_q;

        case (state_q)
            IDLE: begin
                if (d_elig && (!i_elig || !last_dmem_q)) begin
                    state_d     = DMEM_ACC;
                    last_dmem_d = 1'b1;
                    cnt_d       = '0;
                    mem_en_d    = 1'b1;
                    mem_rw_d    = dmem_rw;
                    mem_addr_d  = dmem_addr;
                    mem_wdata_d = dmem_wdata;
                    mem_be_d    = dmem_byte_en;
                end else if (i_elig) begin
                    state_d     = IMEM_ACC;
                    last_dmem_d = 1'b0;
                    cnt_d       = '0;
                    mem_en_d    = 1'b1;
                    mem_rw_d    = 1'b0;
                    mem_addr_d  = imem_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = 4'b1111;
                end
            end
            IMEM_ACC, DMEM_ACC: begin
                cnt_d = cnt_q + 10'd1;
                if (mem_ready || (cnt_q == TO_LAST)) begin
                    state_d  = IDLE;
                    mem_en_d = 1'b0;
                    if (state_q == IMEM_ACC) begin
                        imem_ready_d = 1'b1;
                        imem_error_d = ~mem_ready;
                        imem_rdata_d = mem_ready ? mem_rdata : '0;
                    end else begin
                        dmem_ready_d = 1'b1;
                        dmem_error_d = ~mem_ready;
                        dmem_rdata_d = (mem_ready && !mem_rw_q) ? mem_rdata : '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_dmem_q  <= 1'b0;
            cnt_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_rw_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            imem_ready_q <= 1'b0;
            imem_rdata_q <= '0;
            imem_error_q <= 1'b0;
            dmem_ready_q <= 1'b0;
            dmem_rdata_q <= '0;
            dmem_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_dmem_q  <= last_dmem_d;
            cnt_q        <= cnt_d;
            mem_en_q     <= mem_en_d;
            mem_rw_q     <= mem_rw_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            imem_ready_q <= imem_ready_d;
            imem_rdata_q <= imem_rdata_d;
            imem_error_q <= imem_error_d;
            dmem_ready_q <= dmem_ready_d;
            dmem_rdata_q <= dmem_rdata_d;
            dmem_error_q <= dmem_error_d;
        end
    end

    assign mem_en      = mem_en_q;
    assign mem_rw      = mem_rw_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_byte_en = mem_be_q;
    assign imem_ready  = imem_ready_q;
    assign imem_rdata  = imem_rdata_q;
    assign imem_error  = imem_error_q;
    assign dmem_ready  = dmem_ready_q;
    assign dmem_rdata  = dmem_rdata_q;
    assign dmem_error  = dmem_error_q;
    assign busy        = (state_q != IDLE);

endmodule
